fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding, queue entry layout and the NOP word.
package cpu_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIssue   = 2'd0,
    StWait    = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush clears it in one edge.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != '0);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // The producer never pushes into a full queue, so no overflow guard here.
      if (push_i) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AddrW'(1);
      end
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding-request FSM, next_pc selection and a decode-side queue.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_instr,
  output logic [31:0] fq_pc
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [CntW-1:0] fq_count;
  logic            outstanding;
  logic            room;
  logic            accept;
  logic            push;
  logic            pop;
  logic            head_valid;
  fq_entry_t       push_entry;
  fq_entry_t       head_entry;

  assign outstanding = (state_q != StIssue);
  assign room = ({1'b0, fq_count} + (CntW + 1)'(outstanding)) < (CntW + 1)'(QDEPTH);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    imem_req_valid = 1'b0;
    accept         = 1'b0;
    push           = 1'b0;
    unique case (state_q)
      StIssue: begin
        imem_req_valid = rst_n && !redirect_valid && room;
        if (imem_req_valid && imem_req_ready) begin
          accept  = 1'b1;
          addr_d  = pc_in;
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          // A response landing with the redirect is already stale.
          state_d = imem_rsp_valid ? StIssue : StDiscard;
        end else if (imem_rsp_valid) begin
          push    = 1'b1;
          state_d = StIssue;
        end
      end
      StDiscard: begin
        if (imem_rsp_valid) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_comb begin
    if (!rst_n) begin
      next_pc = RESET_PC;
    end else if (redirect_valid) begin
      next_pc = align_word(redirect_addr);
    end else if (accept) begin
      next_pc = pc_in + 32'd4;
    end else begin
      next_pc = pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIssue;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req_addr    = pc_in;
  assign push_entry.pc    = addr_q;
  assign push_entry.instr = imem_rsp_data;
  assign pop              = head_valid && fq_ready && !redirect_valid;

  fetch_fifo #(
    .Width ($bits(fq_entry_t)),
    .Depth (QDEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .valid_o (head_valid),
    .rdata_o (head_entry),
    .count_o (fq_count)
  );

  assign fq_valid = head_valid;
  assign fq_instr = head_valid ? head_entry.instr : INSTR_NOP;
  assign fq_pc    = head_valid ? head_entry.pc : 32'h0000_0000;

endmodule
